// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: accepts one 128-bit state and transforms it
// COLS_PER_CYCLE columns per cycle in place, with round-based bypass and abort.
module mix_columns_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1,
    parameter bit          OUT_REG        = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         inv,
    input  logic [4:0]   round,
    input  logic [1:0]   mode,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t        state, state_next;
    logic [1:0]    cnt, cnt_next;
    logic [127:0]  result, result_next;
    logic          inv_q, inv_next;
    logic          rdy_en;
    logic          bypass;
    logic          accept;
    logic [1:0]    col_idx;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inverse);
        logic [7:0]  a[4], x2[4], x4[4], x8[4], o[4];
        int unsigned r1, r2, r3;
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        for (int unsigned r = 0; r < 4; r++) begin
            r1 = (r + 1) % 4;
            r2 = (r + 2) % 4;
            r3 = (r + 3) % 4;
            // Coefficients built from xtime chains: 3=2^1, 9=8^1, B=8^2^1, D=8^4^1, E=8^4^2
            if (!inverse)
                o[r] = x2[r] ^ x2[r1] ^ a[r1] ^ a[r2] ^ a[r3];
            else
                o[r] = (x8[r] ^ x4[r] ^ x2[r]) ^ (x8[r1] ^ x2[r1] ^ a[r1])
                     ^ (x8[r2] ^ x4[r2] ^ a[r2]) ^ (x8[r3] ^ a[r3]);
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction

    always_comb begin
        case (mode)
            2'h2:    bypass = (round == 5'h19);
            2'h3:    bypass = (round == 5'h1D);
            default: bypass = (round == 5'h15);
        endcase
    end

    assign in_ready  = (state == IDLE) && rdy_en;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !abort;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        result_next = result;
        inv_next    = inv_q;
        col_idx     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    result_next = in_data;
                    inv_next    = inv;
                    cnt_next    = '0;
                    state_next  = bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
                    col_idx = cnt + 2'(k);
                    result_next[127-32*col_idx -: 32] = mix_col(result[127-32*col_idx -: 32], inv_q);
                end
                cnt_next = cnt + CNT_STEP;
                if (cnt == CNT_LAST)
                    state_next = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next  = IDLE;
            cnt_next    = '0;
            result_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            inv_q  <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            result <= result_next;
            inv_q  <= inv_next;
            rdy_en <= 1'b1;
        end
    end

    // The output stage loads the same next value as the result register, so
    // latency does not depend on OUT_REG.
    if (OUT_REG) begin : g_out_reg
        logic [127:0] out_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                out_q <= '0;
            else
                out_q <= result_next;
        end
        assign out_data = out_q;
    end else begin : g_out_comb
        assign out_data = result;
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2, 4 columns per cycle) share stimulus
// and are checked against a GF(2^8) matrix-product reference model.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, inv, abort, out_ready;
    logic [127:0] in_data;
    logic [4:0]   round;
    logic [1:0]   mode;
    logic         rdy1, rdy2, rdy4, ov1, ov2, ov4;
    logic [127:0] od1, od2, od4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1), .OUT_REG(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .inv(inv), .round(round), .mode(mode), .abort(abort), .out_valid(ov1),
        .out_ready(out_ready), .out_data(od1));
    mix_columns_engine #(.COLS_PER_CYCLE(2), .OUT_REG(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .inv(inv), .round(round), .mode(mode), .abort(abort), .out_valid(ov2),
        .out_ready(out_ready), .out_data(od2));
    mix_columns_engine #(.COLS_PER_CYCLE(4), .OUT_REG(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
        .inv(inv), .round(round), .mode(mode), .abort(abort), .out_valid(ov4),
        .out_ready(out_ready), .out_data(od4));

    typedef struct {
        logic [127:0] d;
        logic         iv;
        logic [4:0]   rd;
        logic [1:0]   md;
        logic [127:0] exp;
        logic         byp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic iv);
        logic [7:0]   coef[4];
        logic [7:0]   acc;
        logic [127:0] r = '0;
        if (iv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(coef[(j + 4 - row) % 4], d[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic is_bypass(input logic [4:0] rd, input logic [1:0] md);
        return (md == 2'h2) ? (rd == 5'h19) : (md == 2'h3) ? (rd == 5'h1D) : (rd == 5'h15);
    endfunction

    // Offer one block to all instances, record each latency and result, optionally hold
    // out_ready low for extra cycles, then hand the results off together.
    task automatic run_block(input string tag, input logic [127:0] d, input logic iv,
                             input logic [4:0] rd, input logic [1:0] md,
                             input logic [127:0] exp, input logic byp, input int hold);
        int l1 = 0, l2 = 0, l4 = 0;
        logic [127:0] g1 = '0, g2 = '0, g4 = '0;
        logic stable = 1'b1;
        @(negedge clk);
        check({tag, " ready"}, {125'd0, rdy1, rdy2, rdy4}, 128'd7);
        in_valid = 1'b1; in_data = d; inv = iv; round = rd; mode = md;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
        inv = ~iv; round = 5'($urandom); mode = 2'($urandom);
        for (int cyc = 1; cyc <= 12 && (l1 == 0 || l2 == 0 || l4 == 0); cyc++) begin
            @(negedge clk);
            if (ov1) begin if (l1 == 0) begin l1 = cyc; g1 = od1; end else if (od1 !== g1) stable = 1'b0; end
            if (ov2) begin if (l2 == 0) begin l2 = cyc; g2 = od2; end else if (od2 !== g2) stable = 1'b0; end
            if (ov4) begin if (l4 == 0) begin l4 = cyc; g4 = od4; end else if (od4 !== g4) stable = 1'b0; end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (od1 !== g1 || od2 !== g2 || od4 !== g4 || {ov1, ov2, ov4} !== 3'b111 ||
                {rdy1, rdy2, rdy4} !== 3'b000) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, " data c1"}, g1, exp);
        check({tag, " data c2"}, g2, exp);
        check({tag, " data c4"}, g4, exp);
        check({tag, " lat c1"}, 128'(l1), byp ? 128'd1 : 128'd5);
        check({tag, " lat c2"}, 128'(l2), byp ? 128'd1 : 128'd3);
        check({tag, " lat c4"}, 128'(l4), byp ? 128'd1 : 128'd2);
        check({tag, " stable"}, {127'd0, stable}, 128'd1);
        check({tag, " idle after"}, {122'd0, ov1, ov2, ov4, rdy1, rdy2, rdy4}, 128'h7);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " out_valid"}, {125'd0, ov1, ov2, ov4}, 128'd0);
        check({tag, " in_ready"}, {125'd0, rdy1, rdy2, rdy4}, 128'd0);
        check({tag, " out_data"}, od1 | od2 | od4, 128'd0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, " ready before edge"}, {125'd0, rdy1, rdy2, rdy4}, 128'd0);
        @(posedge clk); #1;
        check({tag, " ready after edge"}, {125'd0, rdy1, rdy2, rdy4}, 128'd7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[11];
        logic [127:0] d, ex;
        logic [127:0] v29_in, v29_out, dd;
        logic         iv, byp, seen;
        logic [4:0]   rd;
        logic [1:0]   md;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inv = 1'b0; round = '0;
        mode = '0; abort = 1'b0; out_ready = 1'b0;

        v29_in  = 128'hf20a225c_01010101_c6c6c6c6_d4bf5d30;
        v29_out = 128'h9fdc589d_01010101_c6c6c6c6_046681e5;
        dd      = 128'h00112233_44556677_8899aabb_ccddeeff;
        vecs[0]  = '{{4{32'hdb135345}}, 1'b0, 5'h00, 2'h0, {4{32'h8e4da1bc}}, 1'b0};
        vecs[1]  = '{{4{32'h8e4da1bc}}, 1'b1, 5'h01, 2'h1, {4{32'hdb135345}}, 1'b0};
        vecs[2]  = '{v29_in, 1'b0, 5'h03, 2'h1, v29_out, 1'b0};
        vecs[3]  = '{v29_out, 1'b1, 5'h07, 2'h2, v29_in, 1'b0};
        vecs[4]  = '{dd, 1'b0, 5'h1D, 2'h3, dd, 1'b1};
        vecs[5]  = '{dd, 1'b0, 5'h19, 2'h3, ref_mix(dd, 1'b0), 1'b0};
        vecs[6]  = '{dd, 1'b1, 5'h19, 2'h2, dd, 1'b1};
        vecs[7]  = '{dd, 1'b0, 5'h15, 2'h0, dd, 1'b1};
        vecs[8]  = '{dd, 1'b1, 5'h15, 2'h1, dd, 1'b1};
        vecs[9]  = '{dd, 1'b1, 5'h1D, 2'h0, ref_mix(dd, 1'b1), 1'b0};
        vecs[10] = '{dd, 1'b0, 5'h15, 2'h2, ref_mix(dd, 1'b0), 1'b0};

        #12;
        check_reset_outputs("reset");
        release_reset("reset");

        for (int i = 0; i < 11; i++)
            run_block($sformatf("vec%0d", i), vecs[i].d, vecs[i].iv, vecs[i].rd, vecs[i].md,
                      vecs[i].exp, vecs[i].byp, 0);

        for (int i = 0; i < 12; i++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom);
            md = 2'($urandom);
            rd = 5'($urandom);
            if ($urandom_range(0, 2) == 0)
                rd = (md == 2'h2) ? 5'h19 : (md == 2'h3) ? 5'h1D : 5'h15;
            byp = is_bypass(rd, md);
            ex  = byp ? d : ref_mix(d, iv);
            run_block($sformatf("rand%0d", i), d, iv, rd, md, ex, byp, 0);
        end

        run_block("backpressure", v29_in, 1'b0, 5'h02, 2'h0, v29_out, 1'b0, 10);

        // abort in the second BUSY cycle with a bypass block offered at the same time
        @(negedge clk);
        in_valid = 1'b1; in_data = v29_in; inv = 1'b0; round = 5'h00; mode = 2'h0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1; in_valid = 1'b1; in_data = dd; round = 5'h15;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("abort out_valid", {125'd0, ov1, ov2, ov4}, 128'd0);
        check("abort in_ready", {125'd0, rdy1, rdy2, rdy4}, 128'd7);
        check("abort cleared", od1 | od2 | od4, 128'd0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov1 || ov2 || ov4) seen = 1'b1;
        end
        check("abort no output", {127'd0, seen}, 128'd0);

        // abort in IDLE blocks a simultaneous accept
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; in_data = dd; round = 5'h15; mode = 2'h0;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov1 || ov2 || ov4) seen = 1'b1;
        end
        check("idle abort no accept", {127'd0, seen}, 128'd0);

        run_block("post abort", vecs[0].d, 1'b0, 5'h00, 2'h0, vecs[0].exp, 1'b0, 0);

        // asynchronous reset while every instance sits in DONE
        @(negedge clk);
        in_valid = 1'b1; in_data = v29_in; inv = 1'b0; round = 5'h00; mode = 2'h0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 12 && !(ov1 && ov2 && ov4); c++)
            @(negedge clk);
        check("done before reset", {125'd0, ov1, ov2, ov4}, 128'd7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-done reset");
        release_reset("mid-done reset");
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov1 || ov2 || ov4) seen = 1'b1;
        end
        check("reset discards block", {127'd0, seen}, 128'd0);

        run_block("post reset", v29_out, 1'b1, 5'h00, 2'h3, v29_in, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
